mandelbrot_iter_engine: RTL

- Responder end of the coordinate/colour handshake between the frame controller and the escape-time calculator.
- Accepts one complex coordinate c (signed fixed point) per start, iterates z <= z^2 + c from z=0, and returns a 9-bit RGB333 colour on a one-cycle out_ready pulse.
- Sits between the address mapper (coordinate source) and the display-buffer writer.
- Runs on the 25 MHz pixel-domain clock.

---
 rtl/mandelbrot_pkg.sv | 27 ++
 rtl/mandelbrot_palette.sv | 29 ++
 rtl/mandelbrot_iter_engine.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot escape-time engine and its palette.
package mandelbrot_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_FRAC_BITS = 28;
  localparam int DEF_MAX_ITER  = 64;

  // |z|^2 escape threshold, 4.0 in the default fixed-point format
  localparam longint ESCAPE_R2 = longint'(4) <<< DEF_FRAC_BITS;

  localparam int COLOUR_W = 9;
  localparam int FIELD_W  = 3;
  localparam int R_LSB    = 6;
  localparam int G_LSB    = 3;
  localparam int B_LSB    = 0;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  function automatic logic [DEF_DATA_W-1:0] to_fixed(input real value);
    return DEF_DATA_W'(longint'(value * (2.0 ** DEF_FRAC_BITS)));
  endfunction

endpackage

// File: rtl/mandelbrot_palette.sv
// Maps an escape iteration count to an RGB333 colour; points inside the set are black.
module mandelbrot_palette
  import mandelbrot_pkg::*;
#(
  parameter int ITER_W = 7
) (
  input  logic [ITER_W-1:0]   iter,
  input  logic                in_set,
  output logic [COLOUR_W-1:0] colour
);

  logic [FIELD_W-1:0] red;
  logic [FIELD_W-1:0] green;
  logic [FIELD_W-1:0] blue;

  // Red takes the coarse count bits, green the fine bits, blue mirrors green
  always_comb begin
    red    = FIELD_W'(iter >> 3);
    green  = FIELD_W'(iter);
    blue   = 3'd7 - green;
    colour = '0;
    if (!in_set) begin
      colour[R_LSB +: FIELD_W] = red;
      colour[G_LSB +: FIELD_W] = green;
      colour[B_LSB +: FIELD_W] = blue;
    end
  end

endmodule

// File: rtl/mandelbrot_iter_engine.sv
// Escape-time iterator: accepts one coordinate c, iterates z <= z^2 + c from zero,
// and reports an RGB333 colour with a single-cycle out_ready pulse.
module mandelbrot_iter_engine
  import mandelbrot_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int MAX_ITER  = DEF_MAX_ITER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] real_part,
  input  logic [DATA_W-1:0] imaginary_part,
  input  logic              start,
  output logic              ready_for_input,
  output logic              out_ready,
  output logic [DATA_W-1:0] colour_data
);

  localparam int ITER_W = $clog2(MAX_ITER) + 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int MAG_W  = PROD_W + 1;
  localparam logic signed [MAG_W-1:0] ESCAPE_LIMIT = MAG_W'(1) << (FRAC_BITS + 2);

  state_t state;
  state_t next_state;

  logic signed [DATA_W-1:0] cr;
  logic signed [DATA_W-1:0] ci;
  logic signed [DATA_W-1:0] zr;
  logic signed [DATA_W-1:0] zi;
  logic        [ITER_W-1:0] iter;

  logic signed [PROD_W-1:0] zr_ext;
  logic signed [PROD_W-1:0] zi_ext;
  logic signed [PROD_W-1:0] zr2;
  logic signed [PROD_W-1:0] zi2;
  logic signed [PROD_W-1:0] zrzi;
  logic signed [MAG_W-1:0]  mag;

  logic                hit_cap;
  logic                escaped;
  logic                iter_done;
  logic [COLOUR_W-1:0] palette_colour;

  // Full-width products rescaled to the fixed-point format; mag carries an extra bit so it cannot wrap
  assign zr_ext    = PROD_W'(zr);
  assign zi_ext    = PROD_W'(zi);
  assign zr2       = (zr_ext * zr_ext) >>> FRAC_BITS;
  assign zi2       = (zi_ext * zi_ext) >>> FRAC_BITS;
  assign zrzi      = (zr_ext * zi_ext) >>> FRAC_BITS;
  assign mag       = MAG_W'(zr2) + MAG_W'(zi2);

  assign hit_cap   = (iter == ITER_W'(MAX_ITER));
  assign escaped   = (mag > ESCAPE_LIMIT);
  assign iter_done = hit_cap || escaped;

  mandelbrot_palette #(
    .ITER_W (ITER_W)
  ) u_palette (
    .iter   (iter),
    .in_set (hit_cap),
    .colour (palette_colour)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ITER;
      ITER:    if (iter_done) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_for_input = (state == IDLE);
    out_ready       = (state == DONE);
  end

  // Colour is captured on the last ITER cycle so it is already valid while out_ready is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cr          <= '0;
      ci          <= '0;
      zr          <= '0;
      zi          <= '0;
      iter        <= '0;
      colour_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cr   <= real_part;
            ci   <= imaginary_part;
            zr   <= '0;
            zi   <= '0;
            iter <= '0;
          end
        end
        ITER: begin
          if (iter_done) begin
            colour_data <= DATA_W'(palette_colour);
          end else begin
            zr   <= DATA_W'(zr2 - zi2 + PROD_W'(cr));
            zi   <= DATA_W'((zrzi <<< 1) + PROD_W'(ci));
            iter <= iter + ITER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
